// File: rtl/rom_address_display_ctrl.sv
// Seven-segment readout controller: accepts a 9-bit value, converts it to BCD by
// double dabble (one shift per clock) and continuously scans a 4-digit display.
`timescale 1ns/1ps

module rom_address_display_ctrl #(
    parameter int unsigned SCAN_DIVIDER       = 1000,
    parameter bit          LEADING_ZERO_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] value_in,
    input  logic       value_valid,
    output logic       value_ready,
    output logic       busy,
    output logic [7:0] sseg_indicator,
    output logic [3:0] digits
);

    // state   | meaning
    // IDLE    | waiting for a value, value_ready high
    // CONVERT | nine add-3/shift steps of double dabble
    // COMMIT  | copy BCD result into the display register
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    localparam int unsigned PW = $clog2(SCAN_DIVIDER);
    localparam logic [PW-1:0] PRESC_TC = PW'(SCAN_DIVIDER - 1);

    state_t      state_q, state_d;
    logic [8:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] disp_q, disp_d;
    logic [11:0] adj;

    logic [PW-1:0] presc_q;
    logic [1:0]    scan_idx_q;
    logic          scan_on_q;
    logic [1:0]    scan_nxt;
    logic [7:0]    seg_nxt;
    logic [7:0]    sseg_q;
    logic [3:0]    digits_q;

    function automatic logic [11:0] dabble_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        adj     = 12'h000;
        case (state_q)
            S_IDLE: begin
                if (value_valid) begin
                    bin_d   = value_in;
                    bcd_d   = 12'h000;
                    cnt_d   = 4'd9;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                adj            = dabble_adj(bcd_q);
                {bcd_d, bin_d} = {adj[10:0], bin_q, 1'b0};
                cnt_d          = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                disp_d  = bcd_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bin_q   <= 9'd0;
            bcd_q   <= 12'h000;
            cnt_q   <= 4'd0;
            disp_q  <= 12'h000;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
        end
    end

    assign value_ready = (state_q == S_IDLE);
    assign busy        = ~value_ready;

    // The first terminal count after reset strobes index 0; later ones advance.
    assign scan_nxt = scan_on_q ? scan_idx_q + 2'd1 : 2'd0;

    always_comb begin
        seg_nxt = 8'h00;
        case (scan_nxt)
            2'd0: seg_nxt = {seg7(disp_q[3:0]), 1'b0};
            2'd1: begin
                if (!(LEADING_ZERO_BLANK && disp_q[11:8] == 4'd0 && disp_q[7:4] == 4'd0))
                    seg_nxt = {seg7(disp_q[7:4]), 1'b0};
            end
            2'd2: begin
                if (!(LEADING_ZERO_BLANK && disp_q[11:8] == 4'd0))
                    seg_nxt = {seg7(disp_q[11:8]), 1'b0};
            end
            default: seg_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            scan_idx_q <= 2'd0;
            scan_on_q  <= 1'b0;
            sseg_q     <= 8'h00;
            digits_q   <= 4'b0000;
        end else if (presc_q == PRESC_TC) begin
            presc_q    <= '0;
            scan_idx_q <= scan_nxt;
            scan_on_q  <= 1'b1;
            sseg_q     <= seg_nxt;
            digits_q   <= 4'b0001 << scan_nxt;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign sseg_indicator = sseg_q;
    assign digits         = digits_q;

endmodule
